// File: rtl/agusec_fault_pkg.sv
// Shared definitions for the AGU security fault stage: fault codes, the fault
// record layout and the capability tag position.
package agusec_fault_pkg;

    localparam int TAG_BIT    = 64;
    localparam int PTR_W      = 65;
    localparam int REC_ID_W   = 9;
    localparam int REC_ADDR_W = 44;

    typedef enum logic [1:0] {
        FLT_NONE   = 2'b00,
        FLT_BOUNDS = 2'b01,
        FLT_TAG    = 2'b10,
        FLT_BOTH   = 2'b11
    } flt_code_e;

    typedef struct packed {
        logic [REC_ID_W-1:0]   id;
        logic [REC_ADDR_W-1:0] addr;
        flt_code_e             code;
    } flt_rec_t;

    // Plain ops (chk=0) never fault regardless of verdict or tag.
    function automatic flt_code_e fault_code(input logic chk, input logic secq, input logic tag);
        return flt_code_e'({chk & ~tag, chk & ~secq});
    endfunction

endpackage

// File: rtl/agusec_fault_fifo.sv
// Small synchronous FIFO for fault records; head is read straight from storage.
module agusec_fault_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push = push & (count < CW'(DEPTH));
        do_pop  = pop & (count != '0);
    end

    assign dout = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/agusec_fault_stage.sv
// Stage after the AGU range check: registers each op, derives its fault code,
// queues fault records for retire and keeps a saturating debug fault count.
module agusec_fault_stage
    import agusec_fault_pkg::*;
#(
    parameter int ID_W   = 9,
    parameter int ADDR_W = 44,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    output logic              in_rdy,
    input  logic [ID_W-1:0]   in_id,
    input  logic [64:0]       in_ptr,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_chk,
    input  logic              in_secq,
    output logic              out_en,
    output logic [ID_W-1:0]   out_id,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_fault,
    input  logic              out_stall,
    output logic              flt_en,
    output logic [ID_W-1:0]   flt_id,
    output logic [ADDR_W-1:0] flt_addr,
    output logic [1:0]        flt_code,
    input  logic              flt_ack,
    input  logic              flush,
    output logic [CNT_W-1:0]  flt_cnt
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int REC_W = ID_W + ADDR_W + 2;

    flt_code_e         code;
    logic              fault;
    logic              accept;
    logic              push;
    logic              pop;
    logic [CW-1:0]     fifo_cnt;
    logic [REC_W-1:0]  fifo_head;
    logic              unused_ptr;

    assign unused_ptr = ^in_ptr[63:0];

    // A full FIFO blocks every op so that no fault record can ever be lost.
    assign in_rdy = ~out_stall & (fifo_cnt < CW'(DEPTH));
    assign code   = fault_code(in_chk, in_secq, in_ptr[TAG_BIT]);
    assign fault  = |code;
    assign accept = in_en & in_rdy & ~flush;
    assign push   = accept & fault;
    assign pop    = flt_ack & flt_en;

    assign flt_en                       = (fifo_cnt != '0);
    assign {flt_id, flt_addr, flt_code} = fifo_head;

    agusec_fault_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ({in_id, in_addr, code}),
        .dout  (fifo_head),
        .count (fifo_cnt)
    );

    // Flush only drops the valid bit; data registers may keep stale contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_en    <= 1'b0;
            out_id    <= '0;
            out_addr  <= '0;
            out_fault <= 1'b0;
        end else if (flush) begin
            out_en <= 1'b0;
        end else if (!out_stall) begin
            out_en <= accept;
            if (accept) begin
                out_id    <= in_id;
                out_addr  <= in_addr;
                out_fault <= fault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flt_cnt <= '0;
        end else if (push && (flt_cnt != '1)) begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_agusec_fault_stage.sv
// Self-checking bench for agusec_fault_stage: vector table plus hand-written
// sequences, with a fault-record scoreboard queue as the reference.
module tb_agusec_fault_stage;
    import agusec_fault_pkg::*;

    localparam int ID_W   = 9;
    localparam int ADDR_W = 44;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    typedef struct {
        logic              en;
        logic              chk;
        logic              secq;
        logic              tag;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic              stall;
        logic              ack;
        logic              flush;
        logic [1:0]        exp_code;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_en;
    logic              in_rdy;
    logic [ID_W-1:0]   in_id;
    logic [64:0]       in_ptr;
    logic [ADDR_W-1:0] in_addr;
    logic              in_chk;
    logic              in_secq;
    logic              out_en;
    logic [ID_W-1:0]   out_id;
    logic [ADDR_W-1:0] out_addr;
    logic              out_fault;
    logic              out_stall;
    logic              flt_en;
    logic [ID_W-1:0]   flt_id;
    logic [ADDR_W-1:0] flt_addr;
    logic [1:0]        flt_code;
    logic              flt_ack;
    logic              flush;
    logic [CNT_W-1:0]  flt_cnt;

    int n_checks = 0;
    int n_errors = 0;

    flt_rec_t          fq[$];
    logic              m_out_en;
    logic [ID_W-1:0]   m_id;
    logic [ADDR_W-1:0] m_addr;
    logic              m_fault;
    logic [CNT_W-1:0]  m_cnt;

    always #5 clk = ~clk;

    agusec_fault_stage #(
        .ID_W   (ID_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .in_rdy    (in_rdy),
        .in_id     (in_id),
        .in_ptr    (in_ptr),
        .in_addr   (in_addr),
        .in_chk    (in_chk),
        .in_secq   (in_secq),
        .out_en    (out_en),
        .out_id    (out_id),
        .out_addr  (out_addr),
        .out_fault (out_fault),
        .out_stall (out_stall),
        .flt_en    (flt_en),
        .flt_id    (flt_id),
        .flt_addr  (flt_addr),
        .flt_code  (flt_code),
        .flt_ack   (flt_ack),
        .flush     (flush),
        .flt_cnt   (flt_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic chk, input logic secq, input logic tag,
                                input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                                input logic stall, input logic ack, input logic fl);
        vec_t v;
        v.en = en; v.chk = chk; v.secq = secq; v.tag = tag; v.id = id; v.addr = addr;
        v.stall = stall; v.ack = ack; v.flush = fl;
        v.exp_code = {chk & ~tag, chk & ~secq};
        return v;
    endfunction

    task automatic check_output();
        check("out_en", 64'(out_en), 64'(m_out_en));
        if (m_out_en) begin
            check("out_id", 64'(out_id), 64'(m_id));
            check("out_addr", 64'(out_addr), 64'(m_addr));
            check("out_fault", 64'(out_fault), 64'(m_fault));
        end
        check("flt_en", 64'(flt_en), 64'(fq.size() != 0));
        if (fq.size() != 0) begin
            check("flt_id", 64'(flt_id), 64'(fq[0].id));
            check("flt_addr", 64'(flt_addr), 64'(fq[0].addr));
            check("flt_code", 64'(flt_code), 64'(fq[0].code));
        end
        check("flt_cnt", 64'(flt_cnt), 64'(m_cnt));
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic     exp_rdy;
        logic     acc;
        flt_rec_t r;
        @(negedge clk);
        in_en     = v.en;
        in_chk    = v.chk;
        in_secq   = v.secq;
        in_id     = v.id;
        in_addr   = v.addr;
        in_ptr    = {v.tag, 32'($urandom), 32'($urandom)};
        out_stall = v.stall;
        flt_ack   = v.ack;
        flush     = v.flush;
        #1;
        exp_rdy = !v.stall && (fq.size() < DEPTH);
        check("in_rdy", 64'(in_rdy), 64'(exp_rdy));
        acc = v.en && exp_rdy && !v.flush;
        @(posedge clk);
        if (v.flush) begin
            fq.delete();
            m_out_en = 1'b0;
        end else begin
            if (v.ack && fq.size() != 0) begin
                void'(fq.pop_front());
            end
            if (acc && v.exp_code != 2'b00) begin
                r.id   = v.id;
                r.addr = v.addr;
                r.code = flt_code_e'(v.exp_code);
                fq.push_back(r);
                if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
            end
            if (!v.stall) begin
                m_out_en = acc;
                if (acc) begin
                    m_id    = v.id;
                    m_addr  = v.addr;
                    m_fault = (v.exp_code != 2'b00);
                end
            end
        end
        #1;
        check_output();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_en = 1'b0; in_chk = 1'b0; in_secq = 1'b0; in_id = '0;
        in_addr = '0; in_ptr = '0; out_stall = 1'b0; flt_ack = 1'b0; flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fq.delete();
        m_out_en = 1'b0; m_id = '0; m_addr = '0; m_fault = 1'b0; m_cnt = '0;
        #1;
        check("rst out_en", 64'(out_en), 64'd0);
        check("rst out_id", 64'(out_id), 64'd0);
        check("rst out_addr", 64'(out_addr), 64'd0);
        check("rst out_fault", 64'(out_fault), 64'd0);
        check("rst flt_en", 64'(flt_en), 64'd0);
        check("rst flt_id", 64'(flt_id), 64'd0);
        check("rst flt_addr", 64'(flt_addr), 64'd0);
        check("rst flt_code", 64'(flt_code), 64'd0);
        check("rst flt_cnt", 64'(flt_cnt), 64'd0);
        check("rst in_rdy", 64'(in_rdy), 64'd1);
    endtask

    initial begin
        vec_t tbl[6];
        // Hand-written expected fault codes for the basic op mixes.
        tbl[0] = '{1, 1, 1, 1, 9'd5,  44'h123,  0, 0, 0, 2'b00};
        tbl[1] = '{1, 1, 0, 0, 9'd7,  44'hABC,  0, 0, 0, 2'b11};
        tbl[2] = '{1, 0, 0, 0, 9'd9,  44'h456,  0, 0, 0, 2'b00};
        tbl[3] = '{1, 1, 0, 1, 9'd10, 44'h1000, 0, 0, 0, 2'b01};
        tbl[4] = '{1, 1, 1, 0, 9'd11, 44'hFFF_FFFF_FFFF, 0, 0, 0, 2'b10};
        tbl[5] = '{0, 0, 0, 0, 9'd0,  44'h0,    0, 1, 0, 2'b00};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(tbl[i]);
        end

        // Fill the FIFO, then confirm a further op is blocked until a pop.
        apply_stimulus(mk(0, 0, 0, 0, 9'd0, 44'h0, 0, 0, 1));
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(mk(1, 1, 0, 1, 9'(20 + i), 44'(32'h2000 + i), 0, 0, 0));
        end
        apply_stimulus(mk(1, 1, 0, 0, 9'd24, 44'h2400, 0, 0, 0));
        apply_stimulus(mk(0, 0, 0, 0, 9'd0, 44'h0, 0, 1, 0));
        apply_stimulus(mk(1, 1, 1, 1, 9'd25, 44'h2500, 0, 0, 0));

        for (int i = 0; i < 3; i++) begin
            apply_stimulus(mk(1, 1, 1, 1, 9'd26, 44'h2600, 1, 0, 0));
        end

        // Simultaneous push and pop at count 2, then drain and ack while empty.
        apply_stimulus(mk(0, 0, 0, 0, 9'd0, 44'h0, 0, 0, 1));
        apply_stimulus(mk(1, 1, 0, 1, 9'd30, 44'h3000, 0, 0, 0));
        apply_stimulus(mk(1, 1, 0, 0, 9'd31, 44'h3100, 0, 0, 0));
        apply_stimulus(mk(1, 1, 1, 0, 9'd32, 44'h3200, 0, 1, 0));
        apply_stimulus(mk(0, 0, 0, 0, 9'd0, 44'h0, 0, 1, 0));
        apply_stimulus(mk(0, 0, 0, 0, 9'd0, 44'h0, 0, 1, 0));
        apply_stimulus(mk(0, 0, 0, 0, 9'd0, 44'h0, 0, 1, 0));

        // Flush with three queued faults and a valid op in the register.
        apply_stimulus(mk(1, 1, 0, 1, 9'd40, 44'h4000, 0, 0, 0));
        apply_stimulus(mk(1, 1, 1, 0, 9'd41, 44'h4100, 0, 0, 0));
        apply_stimulus(mk(1, 1, 0, 0, 9'd42, 44'h4200, 0, 0, 0));
        apply_stimulus(mk(1, 1, 0, 0, 9'd43, 44'h4300, 0, 1, 1));
        apply_stimulus(mk(1, 1, 1, 1, 9'd44, 44'h4400, 0, 0, 0));

        apply_stimulus(mk(1, 1, 0, 1, 9'd50, 44'h5000, 0, 0, 0));
        do_reset();
        apply_stimulus(mk(1, 1, 0, 0, 9'd51, 44'h5100, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/agusec_fault_stage.md
Name: agusec_fault_stage

Overview:
- Pipeline stage directly downstream of the security range check (the AGU bounds/tag check that produces cout_secq).
- Registers each AGU result for one cycle and merges the range-check verdict with the pointer tag into a per-op fault flag.
- Queues fault records in a small FIFO for the retire/exception logic.
- Keeps a saturating fault counter for debug.

Parameters:
- ID_W, 9, width of the reorder-buffer op id.
- ADDR_W, 44, width of the computed address.
- DEPTH, 4, fault FIFO entries (power of two, at least 2).
- CNT_W, 16, fault counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_en  in  1  AGU op valid this cycle
- in_rdy  out  1  stage can accept an op
- in_id  in  ID_W  op id
- in_ptr  in  65  capability pointer; bit 64 is the tag
- in_addr  in  ADDR_W  computed address
- in_chk  in  1  op needs a security check (0 = plain op, never faults)
- in_secq  in  1  cout_secq from the range check (1 = in bounds)
- out_en  out  1  registered op valid
- out_id  out  ID_W  registered op id
- out_addr  out  ADDR_W  registered address
- out_fault  out  1  registered op faulted
- out_stall  in  1  downstream cannot accept out_*
- flt_en  out  1  FIFO head valid
- flt_id  out  ID_W  head op id
- flt_addr  out  ADDR_W  head faulting address
- flt_code  out  2  01 bounds, 10 tag clear, 11 both
- flt_ack  in  1  pop FIFO head
- flush  in  1  discard everything in flight
- flt_cnt  out  CNT_W  saturating count of faults enqueued

Behaviour:
- Reset: out_en=0, out_id=0, out_addr=0, out_fault=0, flt_en=0, flt_id=0, flt_addr=0, flt_code=0, flt_cnt=0, FIFO empty, in_rdy=1 from the first cycle after reset.
- Fault code for an accepted op:
  - code[0] = in_chk & ~in_secq
  - code[1] = in_chk & ~in_ptr[64]
  - fault = |code
- Accept condition: in_en & in_rdy.
- in_rdy = ~out_stall & (FIFO count < DEPTH), purely combinational.
  - A full FIFO blocks all ops, faulting or not, so fault records are never dropped.
- Pipeline register, one cycle of latency:
  - When ~out_stall: out_* load the accepted op; out_en = accept.
  - When out_stall: out_* hold their values.
- Fault FIFO:
  - Push occurs on accept & fault, in the same cycle the op enters out_*.
  - Pop occurs on flt_ack & flt_en. flt_ack while empty is ignored.
  - flt_* show the head entry combinationally from the storage registers. flt_en = count != 0.
  - Push and pop in the same cycle: count unchanged; entries stay in order.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits wide.
- flt_cnt:
  - Increments on every push and saturates at all-ones.
  - Cleared only by rst, not by flush.
- flush has priority over everything in the same cycle:
  - Next cycle: out_en=0, FIFO empty, flt_en=0.
  - An op presented during flush is not accepted and not counted, but in_rdy still reads as computed.
  - Data registers may keep stale values; only valid bits are cleared.
- rst mid-operation behaves exactly like power-on reset.

Decomposition:
- Shared package holds:
  - the fault code constants (FLT_NONE=0, FLT_BOUNDS=1, FLT_TAG=2, FLT_BOTH=3);
  - a fault record typedef {id, addr, code};
  - the tag bit index (64).
- One natural sub-module: agusec_fault_fifo, a parameterised synchronous FIFO with push/pop/flush/count.
  - The top level holds the pipeline register, fault-code logic and counter.

Test Plan:
- Clean op: in_en=1, in_chk=1, in_secq=1, in_ptr[64]=1, id=5, addr=0x123 -> next cycle out_en=1, out_id=5, out_addr=0x123, out_fault=0; flt_en stays 0; flt_cnt=0.
- Bounds plus tag fault: in_secq=0, in_ptr[64]=0, id=7, addr=0xABC -> out_fault=1; flt_en=1, flt_id=7, flt_addr=0xABC, flt_code=3; flt_cnt=1.
- Plain op: in_chk=0 with in_secq=0 and tag 0 -> out_fault=0, no push.
- FIFO full: push 4 faults with no flt_ack -> in_rdy=0 and out_en=0 next cycle; assert flt_ack one cycle -> head id advances, in_rdy=1.
- Stall and simultaneous push/pop:
  - out_stall=1 for 3 cycles -> out_* held, in_rdy=0.
  - Then with count=2, push and pop in the same cycle -> count stays 2, FIFO order preserved.
- Flush with 3 queued faults and a valid out_en -> next cycle flt_en=0, out_en=0, flt_cnt unchanged at 3.
